// File: rtl/clkdiv_prog.sv
// Programmable clock divider: registered clkout with a ratio of N (high ceil(N/2), low floor(N/2)).
// Supports a one-cycle phase-slip hold, glitch-free stop, and ratio changes deferred to the period boundary.
module clkdiv_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 8
) (
    input  logic             hclkin,
    input  logic             resetn,
    input  logic             enable,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_load,
    input  logic             calib,
    output logic             clkout,
    output logic             tick,
    output logic             div_busy,
    output logic [WIDTH-1:0] div_cur
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] pend_reg, pend_next;
    logic [WIDTH-1:0] cur_next;
    logic [WIDTH-1:0] div_clamped;
    logic [WIDTH-1:0] high_len;
    logic             clk_next, tick_next, busy_next;
    logic             wrap;

    assign div_clamped = (div_val < MIN_DIV) ? MIN_DIV : div_val;
    assign high_len    = div_cur - (div_cur >> 1);
    // A calib edge never counts as the wrap, so the hold always wins over it.
    assign wrap        = (state_reg == RUN) && !calib && (cnt_reg == div_cur - 1'b1);

    always_ff @(posedge hclkin or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (enable) state_next = RUN;
            RUN:     if (wrap && !enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cnt_next  = cnt_reg;
        clk_next  = clkout;
        tick_next = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next  = '0;
                clk_next  = enable;
                tick_next = enable;
            end
            RUN: begin
                if (!calib) begin
                    if (wrap && !enable) begin
                        cnt_next = '0;
                        clk_next = 1'b0;
                    end else begin
                        cnt_next  = wrap ? '0 : cnt_reg + 1'b1;
                        clk_next  = (cnt_next < high_len);
                        tick_next = wrap;
                    end
                end
            end
            default: begin
                cnt_next = '0;
                clk_next = 1'b0;
            end
        endcase
    end

    // Ratio changes land only on a period boundary (or immediately while idle).
    always_comb begin
        pend_next = pend_reg;
        cur_next  = div_cur;
        busy_next = div_busy;
        if (div_load) begin
            pend_next = div_clamped;
            if (wrap) begin
                cur_next  = div_clamped;
                busy_next = 1'b0;
            end else begin
                busy_next = 1'b1;
            end
        end else if (div_busy && (state_reg == IDLE || wrap)) begin
            cur_next  = pend_reg;
            busy_next = 1'b0;
        end
    end

    always_ff @(posedge hclkin or negedge resetn) begin
        if (!resetn) begin
            cnt_reg  <= '0;
            clkout   <= 1'b0;
            tick     <= 1'b0;
            pend_reg <= DEF_DIV;
            div_cur  <= DEF_DIV;
            div_busy <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            clkout   <= clk_next;
            tick     <= tick_next;
            pend_reg <= pend_next;
            div_cur  <= cur_next;
            div_busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_clkdiv_prog.sv
// Bench for clkdiv_prog: a waveform-level reference model pushes expected outputs per edge,
// and an independent monitor pops and compares them on the falling edge.
module tb_clkdiv_prog;

    logic       hclkin = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] div_val = 8'd0;
    logic       div_load = 1'b0;
    logic       calib = 1'b0;
    logic       clkout, tick, div_busy;
    logic [7:0] div_cur;

    clkdiv_prog #(.WIDTH(8), .DEFAULT_DIV(8)) dut (
        .hclkin   (hclkin),
        .resetn   (resetn),
        .enable   (enable),
        .div_val  (div_val),
        .div_load (div_load),
        .calib    (calib),
        .clkout   (clkout),
        .tick     (tick),
        .div_busy (div_busy),
        .div_cur  (div_cur)
    );

    always #5 hclkin = ~hclkin;

    int checks = 0;
    int passed = 0;
    int cycle  = 0;

    // Reference model: the remaining clkout samples of the current period are held in a queue.
    bit         m_run  = 0;
    bit         m_clk  = 0;
    bit         m_tick = 0;
    bit         m_busy = 0;
    logic [7:0] m_n    = 8'd8;
    logic [7:0] m_pend = 8'd8;
    bit         wave[$];
    logic [10:0] exp_q[$];

    task automatic build_period(input logic [7:0] n);
        int hi;
        hi = (int'(n) + 1) / 2;
        wave.delete();
        for (int i = 0; i < int'(n); i++) wave.push_back(i < hi);
    endtask

    task automatic model_reset();
        m_run = 0; m_clk = 0; m_tick = 0; m_busy = 0;
        m_n = 8'd8; m_pend = 8'd8;
        wave.delete();
    endtask

    // Drive inputs for the coming rising edge and push the expected post-edge outputs.
    task automatic drive(input bit en, input logic [7:0] dv, input bit dl, input bit cal);
        bit         wrap;
        logic [7:0] cl;
        enable = en; div_val = dv; div_load = dl; calib = cal;
        wrap = m_run && !cal && (wave.size() == 0);
        cl   = (dv < 8'd2) ? 8'd2 : dv;
        if (dl) begin
            $display("cycle %0d: load div_val=%0d (clamped %0d)%s", cycle, dv, cl, wrap ? " on wrap" : "");
            if (wrap) begin m_n = cl; m_busy = 0; end
            else begin m_pend = cl; m_busy = 1; end
        end else if (m_busy && (!m_run || wrap)) begin
            m_n = m_pend; m_busy = 0;
        end
        if (!m_run) begin
            if (en) begin
                m_run = 1; build_period(m_n);
                m_clk = wave.pop_front(); m_tick = 1;
            end else begin
                m_clk = 0; m_tick = 0;
            end
        end else if (cal) begin
            m_tick = 0;
        end else if (wave.size() == 0) begin
            if (!en) begin
                m_run = 0; m_clk = 0; m_tick = 0;
            end else begin
                build_period(m_n);
                m_clk = wave.pop_front(); m_tick = 1;
            end
        end else begin
            m_clk = wave.pop_front(); m_tick = 0;
        end
        exp_q.push_back({m_clk, m_tick, m_busy, m_n});
    endtask

    task automatic cyc(input bit en, input logic [7:0] dv, input bit dl, input bit cal);
        @(negedge hclkin); #1;
        cycle++;
        drive(en, dv, dl, cal);
    endtask

    // Run with enable high until the model is running, idle of pending loads, with rem samples left.
    task automatic run_until_rem(input int rem, input string what);
        int n = 0;
        while (!(m_run && !m_busy && wave.size() == rem)) begin
            cyc(1, 8'd0, 0, 0);
            n++;
            if (n > 1000) begin
                checks++;
                $display("FAIL %s: model position not reached, actual=timeout required=rem %0d", what, rem);
                return;
            end
        end
    endtask

    task automatic check_direct(input string what, input logic [10:0] act, input logic [10:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: actual=%h required=%h", what, act, req);
    endtask

    always @(negedge hclkin) begin
        logic [10:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({clkout, tick, div_busy, div_cur} === e) passed++;
            else $display("FAIL cycle %0d outputs: actual clk=%b tick=%b busy=%b cur=%0d required clk=%b tick=%b busy=%b cur=%0d",
                          cycle, clkout, tick, div_busy, div_cur, e[10], e[9], e[8], e[7:0]);
        end
    end

    initial begin
        repeat (3) @(negedge hclkin);
        #1 check_direct("reset state", {clkout, tick, div_busy, div_cur}, {1'b0, 1'b0, 1'b0, 8'd8});

        // Release reset with enable high: 4 high / 4 low at N=8.
        @(negedge hclkin); #1;
        resetn = 1'b1;
        cycle++;
        drive(1, 8'd0, 0, 0);
        repeat (24) cyc(1, 8'd0, 0, 0);

        // Mid-period load of 5.
        run_until_rem(3, "load5 position");
        cyc(1, 8'd5, 1, 0);
        repeat (20) cyc(1, 8'd0, 0, 0);

        // Clamp of 0 and 1.
        cyc(1, 8'd0, 1, 0);
        repeat (10) cyc(1, 8'd0, 0, 0);
        cyc(1, 8'd1, 1, 0);
        repeat (10) cyc(1, 8'd0, 0, 0);

        // Phase slip at N=4, mid-period and on the wrap edge.
        cyc(1, 8'd4, 1, 0);
        run_until_rem(2, "calib mid position");
        cyc(1, 8'd0, 0, 1);
        repeat (12) cyc(1, 8'd0, 0, 0);
        run_until_rem(0, "calib wrap position");
        cyc(1, 8'd0, 0, 1);
        repeat (12) cyc(1, 8'd0, 0, 0);

        // Stop request at cnt=1 with N=6, then restart.
        cyc(1, 8'd6, 1, 0);
        run_until_rem(4, "stop position");
        repeat (10) cyc(0, 8'd0, 0, 0);
        repeat (10) cyc(1, 8'd0, 0, 0);

        // Early cancel of a stop request.
        cyc(0, 8'd0, 0, 0);
        repeat (12) cyc(1, 8'd0, 0, 0);

        // Load on the wrap edge at N=8.
        cyc(1, 8'd8, 1, 0);
        run_until_rem(0, "wrap load position");
        cyc(1, 8'd3, 1, 0);
        repeat (10) cyc(1, 8'd0, 0, 0);

        // Largest ratio.
        cyc(1, 8'd255, 1, 0);
        run_until_rem(0, "max ratio position");
        repeat (520) cyc(1, 8'd0, 0, 0);

        // Randomized traffic.
        repeat (2500) begin
            bit         en, dl, cal;
            logic [7:0] dv;
            en  = ($urandom_range(0, 19) != 0);
            dl  = ($urandom_range(0, 29) == 0);
            cal = ($urandom_range(0, 19) == 0);
            dv  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
            cyc(en, dv, dl, cal);
        end

        // Asynchronous reset while clkout is high.
        cyc(1, 8'd5, 1, 0);
        begin
            int n = 0;
            while (!(m_run && m_clk) && n < 600) begin
                cyc(1, 8'd0, 0, 0);
                n++;
            end
        end
        @(negedge hclkin); #2;
        resetn = 1'b0;
        #1 check_direct("async reset", {clkout, tick, div_busy, div_cur}, {1'b0, 1'b0, 1'b0, 8'd8});
        #1 resetn = 1'b1;
        model_reset();
        cycle++;
        drive(1, 8'd0, 0, 0);
        repeat (20) cyc(1, 8'd0, 0, 0);

        @(negedge hclkin); #1;
        check_direct("scoreboard drained", 11'(exp_q.size()), 11'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
